// File: rtl/matrix_operand_dispatcher.sv
// -----------------------------------------------------------------------------
// matrix_operand_dispatcher
//
// Purpose:
//   Collects two square N x N operand matrices A and B (32-bit IEEE-754 words)
//   through a strobe/ack load port. It then presents every (row i of A,
//   column j of B) pair to a downstream consumer in row-major pair order.
//   Each pair is handed over with a four-phase strobe/ack handshake on two
//   independent channels: row and column.
//
// Configuration macro:
//   MATRIX_B_TRANSPOSED_EN - when defined, the second block of N*N words is
//                            B transposed (row-major), so column j is simply
//                            stored row j. When undefined, column j is
//                            gathered down column j of a row-major B.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   load_data     in   32-bit operand word
//   load_stb      in   load_data valid (honoured only while loading)
//   load_ack      out  one-cycle pulse per accepted word
//   load_clr      in   discard operands and restart loading (highest priority)
//   start         in   begin dispatching all N*N pairs (honoured only in READY)
//   row           out  row i of A, element k at bits [32(k+1)-1:32k]
//   row_o_stb     out  row valid
//   row_i_ack     in   downstream accepted row
//   column        out  column j of B, same element packing as row
//   column_o_stb  out  column valid
//   column_i_ack  in   downstream accepted column
//   idx_i, idx_j  out  indices of the pair currently presented
//   busy          out  dispatch sequence in progress
//   done          out  one-cycle pulse after the last pair is released
// -----------------------------------------------------------------------------
module matrix_operand_dispatcher #(
    parameter int number_of_elements = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [31:0]                            load_data,
    input  logic                                   load_stb,
    output logic                                   load_ack,
    input  logic                                   load_clr,
    input  logic                                   start,
    output logic [32*number_of_elements-1:0]       row,
    output logic                                   row_o_stb,
    input  logic                                   row_i_ack,
    output logic [32*number_of_elements-1:0]       column,
    output logic                                   column_o_stb,
    input  logic                                   column_i_ack,
    output logic [((number_of_elements > 1) ? $clog2(number_of_elements) : 1)-1:0] idx_i,
    output logic [((number_of_elements > 1) ? $clog2(number_of_elements) : 1)-1:0] idx_j,
    output logic                                   busy,
    output logic                                   done
);

    localparam int N      = number_of_elements;
    localparam int DATA_W = 32;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int WORDS  = 2 * N * N;
    localparam int ADDR_W = $clog2(WORDS);

    localparam logic [ADDR_W-1:0] W_LAST   = ADDR_W'(WORDS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        LOAD,
        READY,
        PRESENT,
        WAIT_RELEASE,
        NEXT
    } state_t;

    state_t state;
    state_t state_next;

    // Operand storage: words 0..N*N-1 hold A, N*N..2N*N-1 hold B (or B^T).
    logic [DATA_W-1:0] mem [WORDS];

    logic [ADDR_W-1:0] w;
    logic              row_got;
    logic              col_got;
    logic              both_acked;
    logic              last_pair;
    logic              word_accept;

    // An ack counts either if it was latched earlier in this presentation or
    // if it is arriving right now.
    assign both_acked  = (row_got | row_i_ack) & (col_got | column_i_ack);
    assign last_pair   = (idx_i == IDX_LAST) && (idx_j == IDX_LAST);
    assign word_accept = (state == LOAD) && load_stb && !load_clr;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; load_clr overrides every other input.
    always_comb begin
        state_next = state;
        if (load_clr) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:         if (load_stb && (w == W_LAST)) state_next = READY;
                READY:        if (start) state_next = PRESENT;
                PRESENT:      if (both_acked) state_next = WAIT_RELEASE;
                WAIT_RELEASE: if (!row_i_ack && !column_i_ack) state_next = NEXT;
                NEXT:         state_next = last_pair ? READY : PRESENT;
                default:      state_next = LOAD;
            endcase
        end
    end

    // Output logic: both strobes are valid exactly while a pair is presented.
    always_comb begin
        row_o_stb    = 1'b0;
        column_o_stb = 1'b0;
        if (state == PRESENT) begin
            row_o_stb    = 1'b1;
            column_o_stb = 1'b1;
        end
    end

    // Control registers: word counter, pair indices, ack latches, flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w        <= '0;
            idx_i    <= '0;
            idx_j    <= '0;
            load_ack <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            row_got  <= 1'b0;
            col_got  <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            done     <= 1'b0;
            if (load_clr) begin
                w       <= '0;
                busy    <= 1'b0;
                row_got <= 1'b0;
                col_got <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (load_stb) begin
                            load_ack <= 1'b1;
                            w        <= (w == W_LAST) ? '0 : w + ADDR_W'(1);
                        end
                    end
                    READY: begin
                        if (start) begin
                            idx_i <= '0;
                            idx_j <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    PRESENT: begin
                        // Latches are cleared on the way out so the next
                        // presentation starts with no stale acknowledgements.
                        if (both_acked) begin
                            row_got <= 1'b0;
                            col_got <= 1'b0;
                        end else begin
                            if (row_i_ack)    row_got <= 1'b1;
                            if (column_i_ack) col_got <= 1'b1;
                        end
                    end
                    NEXT: begin
                        if (last_pair) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else if (idx_j != IDX_LAST) begin
                            idx_j <= idx_j + IDX_W'(1);
                        end else begin
                            idx_j <= '0;
                            idx_i <= idx_i + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Operand storage is data only and carries no reset.
    always_ff @(posedge clk) begin
        if (word_accept) begin
            mem[w] <= load_data;
        end
    end

    // Operand selection. Storage is frozen outside LOAD and the indices only
    // move in NEXT, so row/column stay stable throughout a presentation.
    always_comb begin
        row    = '0;
        column = '0;
        for (int k = 0; k < N; k++) begin
            row[DATA_W*k +: DATA_W] = mem[ADDR_W'(int'(idx_i) * N + k)];
`ifdef MATRIX_B_TRANSPOSED_EN
            column[DATA_W*k +: DATA_W] = mem[ADDR_W'(N * N + int'(idx_j) * N + k)];
`else
            column[DATA_W*k +: DATA_W] = mem[ADDR_W'(N * N + k * N + int'(idx_j))];
`endif
        end
    end

endmodule
